// File: rtl/pipe_ripple_adder_pkg.sv
// Shared helpers for the pipelined ripple adder: slice width and a
// configuration check used at elaboration time.
package pipe_ripple_adder_pkg;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit width_ok(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple-carry adder assembled from full-adder cells.
module adder_slice #(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          ci_i,
  output logic [SW-1:0] s_o,
  output logic          co_o
);

  logic [SW:0] c;

  assign c[0] = ci_i;

  for (genvar i = 0; i < SW; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign co_o = c[SW];

endmodule

// File: rtl/pipe_ripple_adder.sv
// WIDTH-bit ripple adder cut into STAGES registered slices with a global-stall
// valid/ready pipeline. Define PIPE_RIPPLE_ADDER_SUB_EN to add the sub_i port.
module pipe_ripple_adder
  import pipe_ripple_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int SW     = slice_w(WIDTH, STAGES);
  localparam bit CFG_OK = width_ok(WIDTH, STAGES);

  if (!CFG_OK) begin : g_cfg_err
    $error("pipe_ripple_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign adv        = ~out_valid_o | out_ready_i;
  assign in_ready_o = adv;

`ifdef PIPE_RIPPLE_ADDER_SUB_EN
  // Subtract as A + ~B + 1; folding it in at entry keeps it aligned with its operands.
  assign b_eff   = sub_i ? ~b_i : b_i;
  assign cin_eff = sub_i | cin_i;
`else
  assign b_eff   = b_i;
  assign cin_eff = cin_i;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic                  vld_q, vld_d;
    logic                  cy_q;
    logic [(k+1)*SW-1:0]   sum_q, sum_d;
    logic [SW-1:0]         sa, sb, ss;
    logic                  sci, sco;

    if (k == 0) begin : g_head
      assign sa    = a_i[SW-1:0];
      assign sb    = b_eff[SW-1:0];
      assign sci   = cin_eff;
      assign vld_d = in_valid_i;
      assign sum_d = ss;
    end else begin : g_body
      assign sa    = g_stg[k-1].g_skw.a_q[SW-1:0];
      assign sb    = g_stg[k-1].g_skw.b_q[SW-1:0];
      assign sci   = g_stg[k-1].cy_q;
      assign vld_d = g_stg[k-1].vld_q;
      assign sum_d = {ss, g_stg[k-1].sum_q};
    end

    adder_slice #(.SW(SW)) u_slice (
      .a_i  (sa),
      .b_i  (sb),
      .ci_i (sci),
      .s_o  (ss),
      .co_o (sco)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        vld_q <= vld_d;
        cy_q  <= sco;
        sum_q <= sum_d;
      end
    end

    // Skew registers carry the not-yet-added upper slices; the last stage has none.
    if (k < STAGES-1) begin : g_skw
      logic [(STAGES-1-k)*SW-1:0] a_q, b_q, a_d, b_d;

      if (k == 0) begin : g_src_in
        assign a_d = a_i[WIDTH-1:SW];
        assign b_d = b_eff[WIDTH-1:SW];
      end else begin : g_src_prev
        assign a_d = g_stg[k-1].g_skw.a_q[(STAGES-k)*SW-1:SW];
        assign b_d = g_stg[k-1].g_skw.b_q[(STAGES-k)*SW-1:SW];
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign out_valid_o = g_stg[STAGES-1].vld_q;
  assign sum_o       = g_stg[STAGES-1].sum_q;
  assign cout_o      = g_stg[STAGES-1].cy_q;

endmodule

// File: tb/tb_pipe_ripple_adder.sv
// Randomized and directed bench for pipe_ripple_adder with a queue-based
// arithmetic reference model.
module tb_pipe_ripple_adder;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready, cin, cout, sub;
  logic [WIDTH-1:0] a, b, sum;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int out_cnt  = 0;
  int first_out, last_out;
  logic [WIDTH:0] sb[$];

  always #5 clk = ~clk;

  pipe_ripple_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
    .sub_i       (sub),
`endif
    .cin_i       (cin),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .cout_o      (cout)
  );

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                           input logic mc, input logic ms);
    logic [WIDTH:0] r;
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
    if (ms) r = {1'b0, ma} + {1'b0, ~mb} + (WIDTH+1)'(1);
    else    r = {1'b0, ma} + {1'b0, mb} + (WIDTH+1)'(mc);
`else
    r = {1'b0, ma} + {1'b0, mb} + (WIDTH+1)'(mc);
    if (ms) r = r; // sub has no meaning in add-only builds
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set at the falling edge; handshakes are evaluated just after it.
  task automatic cyc();
    logic in_f, out_f;
    logic [WIDTH:0] e;
    #1;
    in_f  = in_valid & in_ready;
    out_f = out_valid & out_ready;
    if (out_f) begin
      if (sb.size() == 0) check("spurious_out", 32'(out_valid), 32'(0));
      else begin
        e = sb.pop_front();
        check("result", 32'({cout, sum}), 32'(e));
      end
      if (out_cnt == 0) first_out = cycle;
      last_out = cycle;
      out_cnt++;
    end
    if (in_f) sb.push_back(model(a, b, cin, sub));
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 64 && sb.size() != 0; i++) cyc();
    check("drain_empty", 32'(sb.size()), 32'(0));
  endtask

  task automatic directed(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tc, input logic ts, input logic [WIDTH-1:0] es, input logic ec);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      check({tag, "_vld"}, 32'(out_valid), 32'(i == STAGES-1));
      if (i == STAGES-1) begin
        check({tag, "_sum"},  32'(sum),  32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
      end
      cyc();
    end
    sub = 1'b0;
  endtask

  initial begin
    logic [WIDTH+1:0] hold;
    logic             any;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1;
    check("rst_vld",  32'(out_valid), 32'(0));
    check("rst_sum",  32'(sum),       32'(0));
    check("rst_cout", 32'(cout),      32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("rst_rdy", 32'(in_ready), 32'(1));
    @(negedge clk);

    directed("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    directed("ones_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    directed("mid", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0);
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
    directed("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    directed("sub_7_5", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
`endif

    // Back-to-back stream
    out_cnt = 0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      #1 check("b2b_rdy", 32'(in_ready), 32'(1));
      #0 cyc();
    end
    drain();
    check("b2b_cnt", 32'(out_cnt), 32'(8));
    check("b2b_consec", 32'(last_out - first_out), 32'(7));

    // Fill with the consumer stalled, then hold for five cycles
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 16 && !out_valid; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      cyc();
    end
    check("stall_full", 32'(out_valid), 32'(1));
    hold = {out_valid, cout, sum};
    for (int i = 0; i < 5; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      #1 check("stall_rdy", 32'(in_ready), 32'(0));
      #0 cyc();
      check("stall_hold", 32'({out_valid, cout, sum}), 32'(hold));
    end
    drain();
    check("stall_cnt", 32'(sb.size()), 32'(0));

    // Reset with results in flight
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      a = WIDTH'($urandom) | 16'h0100; b = WIDTH'($urandom); cin = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_vld", 32'(out_valid), 32'(0));
    check("mid_rst_sum", 32'(sum),       32'(0));
    check("mid_rst_cout", 32'(cout),     32'(0));
    sb.delete();
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1; any = 1'b0;
    for (int i = 0; i < 2*STAGES; i++) begin
      any |= out_valid;
      cyc();
    end
    check("post_rst_quiet", 32'(any), 32'(0));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a   = ($urandom_range(0, 15) == 0) ? '1 : WIDTH'($urandom);
      b   = ($urandom_range(0, 15) == 0) ? '1 : WIDTH'($urandom);
      cin = 1'($urandom);
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
      sub = 1'($urandom);
`endif
      cyc();
    end
    sub = 1'b0;
    drain();
    #1 check("end_idle", 32'(out_valid), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
